fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Sits directly upstream of the load-use hazard detector and consumes its PCEnable / IF_ID_writeEnable outputs.
- Also accepts branch redirects from EX and produces IF_ID_pc / IF_ID_instr / IF_ID_valid for decode.
- Tolerates variable-latency instruction memory, with one request outstanding at most.

Parameters:
- XLEN, 64: PC / address width.
- RESET_PC, 64'h0: first fetch address after reset.
- NOP_INSTR, 32'h00000013: bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- PCEnable  in  1  from hazard unit; 0 = do not advance PC.
- IF_ID_writeEnable  in  1  from hazard unit; 0 = IF/ID holds its contents.
- branch_taken  in  1  redirect strobe from EX, one cycle.
- branch_target  in  XLEN  redirect address; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1 and the response is pending.
- imem_rvalid  in  1  response valid; at least 1 cycle after request acceptance.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- IF_ID_pc  out  XLEN  PC of the latched instruction.
- IF_ID_instr  out  32  latched instruction, or NOP_INSTR for a bubble.
- IF_ID_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async, immediate) values:
  - pc=RESET_PC, req_addr=RESET_PC, state=REQ, discard=0.
  - imem_req=0 while reset is asserted.
  - IF_ID_valid=0, IF_ID_instr=NOP_INSTR, IF_ID_pc=0.
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- Request/address rules:
  - imem_addr is driven from the registered req_addr, never combinationally from pc.
  - A new address is launched only in the cycle after the previous response.
- State REQ (request outstanding, imem_req=1):
  - rvalid & discard: drop the word; discard<=0; re-request at pc (the redirect target).
  - rvalid & IF_ID_writeEnable & PCEnable: IF/ID<={pc, rdata, valid=1}; pc<=pc+4; req_addr<=pc+4; stay in REQ.
  - rvalid & stalled (either enable low): buffer {pc, rdata} in hold register; go to HOLD; imem_req=0.
  - no rvalid: IF/ID takes a bubble if IF_ID_writeEnable=1, else holds.
- State HOLD (imem_req=0):
  - When IF_ID_writeEnable & PCEnable: IF/ID<=hold entry; pc<=pc+4; req_addr<=pc+4; go to REQ.
  - Otherwise stay in HOLD; IF/ID holds.
- Mixed enables: PCEnable=1 with IF_ID_writeEnable=0 (or the reverse) is a stall; no instruction is consumed.
- Redirect (branch_taken=1) has highest priority in any state:
  - pc<=target, IF/ID<=bubble (flush, ignores IF_ID_writeEnable), hold entry dropped, state<=REQ.
  - If a request is outstanding and rvalid=0 that cycle: discard<=1, and req_addr is unchanged until that response arrives.
  - If rvalid=1 in the same cycle: the word is dropped and req_addr<=target next cycle.
  - If in HOLD or no request is outstanding: req_addr<=target next cycle.
- Back-to-back redirects: the latest target wins; discard stays 1 until exactly one pending response is consumed.
- pc+4 wraps modulo 2^XLEN; no exception is raised.
- Throughput: one instruction per response; imem latency L gives one instruction per L+1 cycles.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output ports stall_cycles (32) and flush_count (32), both reset to 0, saturating at 32'hFFFFFFFF.
  - stall_cycles increments each cycle the block is in HOLD, or receives rvalid while stalled.
  - flush_count increments on each branch_taken.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
- Shared package pipeline_pkg:
  - fetch_state_t enum {REQ, HOLD}.
  - if_id_t struct {pc, instr, valid}.
  - NOP_INSTR constant, reused by decode/flush logic.
- One natural sub-module, if_id_reg: the IF/ID register with write enable, synchronous flush-to-bubble and async reset. Flush has priority over enable.

Test Plan:
- Reset then imem with 1-cycle latency returning 0x00500093 at 0x0 -> IF_ID_valid=1, IF_ID_pc=0, IF_ID_instr=0x00500093; next imem_addr=0x4.
- Drop PCEnable and IF_ID_writeEnable for 3 cycles while the response for 0x8 arrives -> IF/ID holds, imem_req=0. On release, IF_ID_pc=0x8 and imem_addr=0xC.
- branch_taken with branch_target=0x100 while a request to 0x10 is outstanding (rvalid 2 cycles later) -> that word is dropped, IF_ID_valid=0, next imem_addr=0x100.
- branch_taken coincident with rvalid -> word dropped, bubble in IF/ID, imem_addr=0x100 on the following cycle.
- PC at 0xFFFF_FFFF_FFFF_FFFC fetched and consumed -> next imem_addr=0x0.
- FETCH_PERF_EN defined: 4 stall cycles and 2 redirects -> stall_cycles=4, flush_count=2; reset asserted mid-run -> both 0 immediately.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: fetch FSM states, IF/ID bundle and bubble encoding.
// Imported by fetch_stage and if_id_reg.
package pipeline_pkg;

    localparam int unsigned PC_W = 64;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    function automatic if_id_t bubble(input logic [31:0] nop);
        if_id_t b;
        b.pc    = '0;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: write enable, synchronous flush-to-bubble, async reset.
// Ports: clk, reset, wr_en, flush (wins over wr_en), d, q.
module if_id_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP = 32'h0000_0013
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   wr_en,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= bubble(NOP);
        end else if (flush) begin
            q <= bubble(NOP);
        end else if (wr_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, IF/ID register.
// Ports: hazard enables, EX redirect, imem req/addr/rvalid/rdata, IF_ID_* out.
// Optional FETCH_PERF_EN adds stall_cycles / flush_count counters.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned      XLEN      = 64,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCEnable,
    input  logic            IF_ID_writeEnable,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [31:0]     IF_ID_instr,
    output logic            IF_ID_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_count
`endif
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] hold_pc_q;
    logic [31:0]     hold_instr_q;
    logic            hold_load;

    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] target;
    logic            go;
    logic            ifid_we;
    logic            ifid_flush;
    if_id_t          ifid_d;
    if_id_t          ifid_q;
    logic            unused_tgt_lsb;

    assign target         = {branch_target[XLEN-1:2], 2'b00};
    assign unused_tgt_lsb = ^branch_target[1:0];
    assign pc_inc         = pc_q + FOUR;
    assign go             = PCEnable & IF_ID_writeEnable;

    assign imem_req  = (state_q == REQ) & ~reset;
    assign imem_addr = req_addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else if (hold_load) begin
            hold_pc_q    <= pc_q;
            hold_instr_q <= imem_rdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        discard_d    = discard_q;
        hold_load    = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        ifid_d.pc    = PC_W'(pc_q);
        ifid_d.instr = imem_rdata;
        ifid_d.valid = 1'b1;

        if (branch_taken) begin
            pc_d       = target;
            ifid_flush = 1'b1;
            state_d    = REQ;
            if (state_q == REQ && !imem_rvalid) begin
                // keep addr stable until the in-flight word returns
                discard_d = 1'b1;
            end else begin
                discard_d  = 1'b0;
                req_addr_d = target;
            end
        end else begin
            unique case (state_q)
                REQ: begin
                    unique case (1'b1)
                        !imem_rvalid: begin
                            ifid_flush = IF_ID_writeEnable;
                        end
                        imem_rvalid && discard_q: begin
                            discard_d  = 1'b0;
                            req_addr_d = pc_q;
                            ifid_flush = IF_ID_writeEnable;
                        end
                        imem_rvalid && !discard_q && go: begin
                            ifid_we    = 1'b1;
                            pc_d       = pc_inc;
                            req_addr_d = pc_inc;
                        end
                        imem_rvalid && !discard_q && !go: begin
                            hold_load  = 1'b1;
                            state_d    = HOLD;
                            ifid_flush = IF_ID_writeEnable;
                        end
                        default: ;
                    endcase
                end
                HOLD: begin
                    if (go) begin
                        ifid_we      = 1'b1;
                        ifid_d.pc    = PC_W'(hold_pc_q);
                        ifid_d.instr = hold_instr_q;
                        pc_d         = pc_inc;
                        req_addr_d   = pc_inc;
                        state_d      = REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    if_id_reg #(
        .NOP (NOP_INSTR)
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .wr_en (ifid_we),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign IF_ID_pc    = ifid_q.pc[XLEN-1:0];
    assign IF_ID_instr = ifid_q.instr;
    assign IF_ID_valid = ifid_q.valid;

`ifdef FETCH_PERF_EN
    logic stall_evt;

    assign stall_evt = (state_q == HOLD) |
                       ((state_q == REQ) & imem_rvalid & ~go);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_evt && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (branch_taken && flush_count != '1) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
